// File: rtl/eeprom_programmer.sv
// Streams a byte burst into an EEPROM, reading each cell back (3 cycles/byte minimum);
// the source is stalled by byte_ready, which is high only while waiting for the next byte.
module eeprom_programmer #(
    parameter int ADDR_W      = 10,
    parameter int EEPROM_SIZE = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ram_in,
    output logic              mem_ram_out,
    input  logic [7:0]        mem_q,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WRITE,
        VERIFY,
        FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(EEPROM_SIZE - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   remaining;

    always_comb begin
        state_nxt   = state;
        byte_ready  = 1'b0;
        mem_ram_in  = 1'b0;
        mem_ram_out = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? FINISH : WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_ram_in = 1'b1;
                state_nxt  = VERIFY;
            end
            VERIFY: begin
                mem_ram_out = 1'b1;
                state_nxt   = (remaining == LEN_ONE) ? FINISH : WAIT_BYTE;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // mem_addr/mem_data are only reloaded when a byte is accepted, so the EEPROM
    // pins stay frozen while the counter advances between bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            remaining  <= '0;
            mem_data   <= '0;
            mem_addr   <= '0;
            verify_err <= 1'b0;
            err_addr   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt   <= base_addr;
                        remaining  <= length;
                        verify_err <= 1'b0;
                        err_addr   <= '0;
                    end
                end
                WAIT_BYTE: begin
                    if (byte_valid) begin
                        mem_data <= byte_in;
                        mem_addr <= addr_cnt;
                    end
                end
                VERIFY: begin
                    if ((mem_q != mem_data) && !verify_err) begin
                        verify_err <= 1'b1;
                        err_addr   <= mem_addr;
                    end
                    addr_cnt  <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_ONE;
                    remaining <= remaining - LEN_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_programmer.sv
// Bench for eeprom_programmer: EEPROM model with an injectable stuck bit, a phase-queue
// reference model compared every cycle, and directed plus randomized bursts.
module tb_eeprom_programmer;

    localparam int ADDR_W = 10;
    localparam int SIZE   = 1024;
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_WRITE = 2, PH_VERIFY = 3, PH_FINISH = 4;

    logic              clk = 1'b0;
    logic              reset, start, byte_valid;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [7:0]        byte_in;
    logic              byte_ready, mem_ram_in, mem_ram_out, busy, done, verify_err;
    logic [7:0]        mem_data, mem_q;
    logic [ADDR_W-1:0] mem_addr, err_addr;

    always #5 clk = ~clk;

    eeprom_programmer #(.ADDR_W(ADDR_W), .EEPROM_SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_ram_in(mem_ram_in),
        .mem_ram_out(mem_ram_out), .mem_q(mem_q), .busy(busy), .done(done),
        .verify_err(verify_err), .err_addr(err_addr)
    );

    // EEPROM: load on mem_ram_in, gated read; optional stuck-at-0 on bit0 of cell 8
    logic [7:0] eeprom [SIZE];
    logic       fault;
    always @(posedge clk) if (mem_ram_in) eeprom[mem_addr] <= mem_data;
    assign mem_q = mem_ram_out ?
                   (eeprom[mem_addr] & ((fault && mem_addr == 10'd8) ? 8'hFE : 8'hFF)) : 8'h00;

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of the cycle kinds the burst still owes
    int                plan[$];
    logic [ADDR_W-1:0] m_addr, m_wa, m_ea;
    logic [7:0]        m_wd;
    logic              m_err;
    int                m_left, m_acc, m_wcnt;
    logic [7:0]        ref_mem [SIZE];
    int                cyc = 0, start_cyc = 0, done_cyc = 0, busy_cnt = 0, wr_pulses = 0;
    logic              chk_en = 1'b0;
    logic [7:0]        src [32];

    function automatic int cur_phase();
        return (plan.size() == 0) ? PH_IDLE : plan[0];
    endfunction

    always @(posedge clk) begin : model
        int         cur;
        logic [7:0] rb;
        cur = cur_phase();
        if (reset) begin
            plan.delete();
            m_addr = '0; m_wa = '0; m_wd = '0; m_err = 1'b0; m_ea = '0; m_left = 0;
        end else if (cur == PH_IDLE) begin
            if (start) begin
                m_addr = base_addr; m_left = int'(length); m_err = 1'b0; m_ea = '0;
                m_acc = 0; m_wcnt = 0; start_cyc = cyc; done_cyc = -1000;
                busy_cnt = 0; wr_pulses = 0;
                plan.push_back(length == 0 ? PH_FINISH : PH_WAIT);
            end
        end else if (cur == PH_WAIT) begin
            if (byte_valid) begin
                void'(plan.pop_front());
                m_wa = m_addr; m_wd = byte_in; m_acc++; m_left--;
                plan.push_back(PH_WRITE);
                plan.push_back(PH_VERIFY);
                plan.push_back(m_left == 0 ? PH_FINISH : PH_WAIT);
            end
        end else if (cur == PH_WRITE) begin
            void'(plan.pop_front());
            ref_mem[m_wa] = m_wd;
            m_wcnt++;
        end else if (cur == PH_VERIFY) begin
            void'(plan.pop_front());
            rb = ref_mem[m_wa] & ((fault && m_wa == 10'd8) ? 8'hFE : 8'hFF);
            if (rb != m_wd && !m_err) begin
                m_err = 1'b1;
                m_ea  = m_wa;
            end
            m_addr = ADDR_W'((int'(m_addr) + 1) % SIZE);
        end else begin
            void'(plan.pop_front());
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        int cur;
        if (chk_en) begin
            cur = cur_phase();
            chk("byte_ready", byte_ready, cur == PH_WAIT);
            chk("mem_ram_in", mem_ram_in, cur == PH_WRITE);
            chk("mem_ram_out", mem_ram_out, cur == PH_VERIFY);
            chk("busy", busy, cur != PH_IDLE);
            chk("done", done, cur == PH_FINISH);
            chk("mem_addr", mem_addr, m_wa);
            chk("mem_data", mem_data, m_wd);
            chk("verify_err", verify_err, m_err);
            chk("err_addr", err_addr, m_ea);
            chk("strobe_exclusive", mem_ram_in & mem_ram_out, 0);
            if (done === 1'b1) done_cyc = cyc;
            if (busy === 1'b1) busy_cnt++;
            if (mem_ram_in === 1'b1) wr_pulses++;
        end
    end

    task automatic burst(input int base, input int len, input bit rnd_valid, input bit poke);
        int budget;
        start = 1'b1; base_addr = ADDR_W'(base); length = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (plan.size() != 0 && budget < 300) begin
            byte_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in    = src[m_acc % 32];
            if (poke) begin
                start     = ($urandom_range(0, 3) == 0);
                base_addr = ADDR_W'($urandom);
                length    = (ADDR_W+1)'($urandom_range(0, 8));
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0; byte_valid = 1'b0;
        chk("burst_within_budget", budget < 300, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int budget, base, len, bad;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        byte_in = '0; byte_valid = 1'b0; fault = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            eeprom[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_byte_ready", byte_ready, 0);

        // base 5, three bytes, valid always high
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
        burst(5, 3, 0, 0);
        chk("b1_cell5", eeprom[5], 8'h11);
        chk("b1_cell6", eeprom[6], 8'h22);
        chk("b1_cell7", eeprom[7], 8'h33);
        chk("b1_done_offset", done_cyc - start_cyc, 10);
        chk("b1_verify_err", verify_err, 0);
        chk("b1_write_pulses", wr_pulses, 3);

        // address wrap from the last cell
        src[0] = 8'hAA; src[1] = 8'h55;
        burst(1023, 2, 0, 0);
        chk("wrap_cell1023", eeprom[1023], 8'hAA);
        chk("wrap_cell0", eeprom[0], 8'h55);
        chk("wrap_verify_err", verify_err, 0);

        // zero-length burst
        burst(300, 0, 0, 0);
        chk("len0_write_pulses", wr_pulses, 0);
        chk("len0_done_offset", done_cyc - start_cyc, 1);
        chk("len0_busy_cycles", busy_cnt, 1);

        // stuck bit at cell 8
        fault = 1'b1;
        src[0] = 8'h01; src[1] = 8'h03; src[2] = 8'h05;
        burst(7, 3, 0, 0);
        chk("fault_verify_err", verify_err, 1);
        chk("fault_err_addr", err_addr, 8);
        chk("fault_model_err_addr", m_ea, 8);
        chk("fault_done_offset", done_cyc - start_cyc, 10);
        fault = 1'b0;

        // reset in the middle of a burst, right after the second WRITE
        for (int i = 0; i < 32; i++) src[i] = 8'($urandom);
        start = 1'b1; base_addr = 10'd20; length = 11'd5;
        @(posedge clk); #1 start = 1'b0;
        budget = 0;
        while (m_wcnt != 2 && budget < 300) begin
            byte_valid = 1'($urandom_range(0, 1));
            byte_in    = src[m_acc % 32];
            @(posedge clk); #1;
            budget++;
        end
        chk("rst_mid_reached_write2", m_wcnt, 2);
        reset = 1'b1; byte_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; byte_valid = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mem_data", mem_data, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        chk("rst_mid_strobes", {mem_ram_in, mem_ram_out, byte_ready, done}, 0);
        src[0] = 8'h5A; src[1] = 8'hC3;
        burst(40, 2, 1, 0);
        chk("after_rst_cell40", eeprom[40], 8'h5A);
        chk("after_rst_cell41", eeprom[41], 8'hC3);

        // start pokes while busy must not disturb the burst
        for (int i = 0; i < 4; i++) src[i] = 8'(8'h70 + i);
        burst(100, 4, 1, 1);
        for (int i = 0; i < 4; i++) chk("poke_cell", eeprom[100 + i], 8'h70 + i);
        chk("poke_write_pulses", wr_pulses, 4);

        // randomized bursts
        for (int k = 0; k < 8; k++) begin
            base = $urandom_range(0, SIZE - 1);
            len  = $urandom_range(0, 6);
            for (int i = 0; i < 32; i++) src[i] = 8'($urandom);
            burst(base, len, 1, 1);
            chk("rand_write_pulses", wr_pulses, len);
        end

        bad = 0;
        for (int i = 0; i < SIZE; i++) if (eeprom[i] !== ref_mem[i]) bad++;
        chk("final_mem_image", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
